tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Programmable note sequencer that drives the frequency command stream of the sine wavetable generator.
- Holds a small table of entries. Each entry is a frequency word plus a duration counted in output samples.
- On start, walks the table, issues one frequency beat per entry, holds it for its duration, and drives a gate signal so downstream mixing can mute rests.
- Sits between the PS-facing control registers and the wavetable freq input.

Parameters:
- DEPTH, 16, number of table entries (power of two).
- DUR_W, 16, duration field width in samples.
- F_SAMPLE, 48_000, sample rate in Hz.
- F_CLOCK, 100_000_000, clk frequency in Hz.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- wr_en  in  1  table write strobe
- wr_addr  in  $clog2(DEPTH)  table write address
- wr_freq  in  24  frequency, unsigned 15.9 fixed point (Hz)
- wr_dur  in  DUR_W  duration in samples; 0 = end marker
- length  in  $clog2(DEPTH)+1  number of entries to play, sampled at start
- start  in  1  single-cycle start pulse
- stop  in  1  single-cycle abort pulse
- loop  in  1  wrap to entry 0 at end (only with TONE_SEQ_LOOP_EN)
- freq_out  Axis_If.Master  24-bit data  frequency command to wavetable
- gate  out  1  high while a non-rest entry is playing
- busy  out  1  high in any state other than IDLE
- step_idx  out  $clog2(DEPTH)  index of the current entry
- done  out  1  one-cycle pulse at sequence completion or abort

Behaviour:
- Table: DEPTH x (24+DUR_W) synchronous-read RAM with 1-cycle read latency.
  - Writes are accepted in any state.
  - A write and a read of the same address in the same cycle returns the old data.
- Sample tick: free-running counter with period TICK = F_CLOCK/F_SAMPLE (integer division; 2083 at the defaults). It emits a 1-cycle tick when it wraps. Reset clears it to 0.
- Reset values: state=IDLE, freq_out.valid=0, freq_out.data=0, gate=0, busy=0, step_idx=0, done=0, all counters 0.
- States:
  - IDLE: wait for start.
    - start with length==0: pulse done next cycle and stay in IDLE.
    - start otherwise: latch length, set step_idx=0, go to READ.
    - start while busy is ignored.
  - READ (1 cycle): present step_idx to the RAM, go to LOAD.
  - LOAD (1 cycle): capture freq and dur.
    - dur==0: go to FINISH.
    - Otherwise: set freq_out.data=freq, freq_out.valid=1, go to SEND.
  - SEND: hold valid and data until freq_out.ready.
    - On the handshake: drop valid, load dur_cnt=dur, set gate=(freq!=0), go to PLAY.
  - PLAY: decrement dur_cnt on each tick.
    - On the tick where dur_cnt==1: drop gate and increment step_idx.
    - If the new index equals the latched length, go to FINISH; otherwise go to READ.
  - FINISH: issue a freq beat of 0 (valid until ready) to freeze the phasor. After the handshake, pulse done, go to IDLE, and reset step_idx to 0.
- Start latency: start in cycle 0, freq_out.valid rises in cycle 3.
- Entry playing time is dur ticks after the handshake, with up to 1 tick of phase jitter because the tick counter is not realigned.
- freq==0 entries are rests: the beat is still sent, but gate stays low.
- stop from any non-IDLE state:
  - gate drops on the next cycle.
  - Any pending beat in SEND is withdrawn only if it has not yet handshaken. valid is allowed to drop on abort; this is a documented deviation from strict AXIS.
  - Go to FINISH.
  - stop in IDLE is ignored.
  - stop and start in the same cycle: stop wins.
- Reset mid-operation: immediate return to reset values. No zero beat is sent.
- freq_out.data is stable while valid is high and ready is low.

Optional Feature:
- Macro: TONE_SEQ_LOOP_EN.
- Defined: in PLAY, when the new index equals length and loop==1, step_idx wraps to 0 and the FSM goes to READ with no FINISH and no done pulse. loop is sampled at each wrap decision. A dur==0 end marker still terminates.
- Undefined: the loop port exists but is ignored. The sequence always ends via FINISH.

Test Plan:
- Timing setup: F_CLOCK=480_000 so that TICK=10. Apply reset and hold ready=1 unless stated otherwise.
- Basic sequence:
  - Table {0:(440<<9, 3), 1:(880<<9, 2)}, length=2, start.
  - Expect beats 0x037000 then 0x06E000, then 0x000000.
  - gate high about 30 then about 20 cycles.
  - One done pulse; busy low afterwards.
- Rest and end marker:
  - Table {0:(0, 2), 1:(1000<<9, 0)}, length=4.
  - Expect beat 0 with gate low for about 20 cycles, then FINISH beat 0 and done.
  - No beat for entry 1.
- Backpressure:
  - ready held low for 7 cycles during SEND.
  - valid stays high and data is stable; PLAY begins the cycle after ready rises.
- Abort:
  - stop asserted 5 cycles into PLAY of entry 0.
  - gate low the next cycle; a 0 beat is issued; done pulses; busy=0.
  - A simultaneous start and stop in IDLE produces no activity.
- Edge cases:
  - length=0 start: done pulses 1 cycle later with no beats.
  - reset asserted mid-PLAY: valid, gate and busy are 0 the next cycle.
  - A start pulse while busy is ignored.
- Loop (TONE_SEQ_LOOP_EN):
  - length=2, loop=1: beat sequence repeats A,B,A,B with no done.
  - Deassert loop during the second B: FINISH and done after that B.

Source files
------------

// File: rtl/tone_sequencer.sv
// Table-driven note sequencer feeding frequency beats to the wavetable generator.
// Optional macro TONE_SEQ_LOOP_EN enables wrapping back to entry 0 while loop is high.
`timescale 1ns/1ps
module tone_sequencer #(
    parameter int DEPTH    = 16,
    parameter int DUR_W    = 16,
    parameter int F_SAMPLE = 48_000,
    parameter int F_CLOCK  = 100_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [23:0]                wr_freq,
    input  logic [DUR_W-1:0]           wr_dur,
    input  logic [$clog2(DEPTH):0]     length,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop,
    output logic                       freq_out_valid,
    input  logic                       freq_out_ready,
    output logic [23:0]                freq_out_data,
    output logic                       gate,
    output logic                       busy,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic                       done
);

    localparam int AW   = $clog2(DEPTH);
    localparam int TICK = F_CLOCK / F_SAMPLE;
    localparam int TW   = (TICK > 1) ? $clog2(TICK) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LOAD, S_SEND, S_PLAY, S_FINISH
    } state_e;

    state_e                  state_q;
    logic [23+DUR_W:0]       mem [DEPTH];
    logic [23+DUR_W:0]       rd_data_q;
    logic [TW-1:0]           tick_cnt_q;
    logic                    tick;
    logic [AW:0]             len_q;
    logic [AW-1:0]           step_idx_q;
    logic [AW:0]             next_idx;
    logic [DUR_W-1:0]        dur_q;
    logic [DUR_W-1:0]        dur_cnt_q;
    logic                    freq_out_valid_q;
    logic [23:0]             freq_out_data_q;
    logic                    gate_q;
    logic                    done_q;
    logic                    abort;

`ifndef TONE_SEQ_LOOP_EN
    logic unused_loop;
    assign unused_loop = loop;
`endif

    // NOTE: the table RAM carries no reset so it maps onto block RAM; only control state is reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= {wr_freq, wr_dur};
    end

    // Registered read: a same-cycle write to this address is seen one cycle later.
    always_ff @(posedge clk) begin
        rd_data_q <= mem[step_idx_q];
    end

    assign tick = (tick_cnt_q == TW'(TICK - 1));

    always_ff @(posedge clk) begin
        if (reset)     tick_cnt_q <= '0;
        else if (tick) tick_cnt_q <= '0;
        else           tick_cnt_q <= tick_cnt_q + 1'b1;
    end

    assign next_idx = {1'b0, step_idx_q} + 1'b1;
    assign abort    = stop && (state_q != S_IDLE) && (state_q != S_FINISH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            len_q            <= '0;
            step_idx_q       <= '0;
            dur_q            <= '0;
            dur_cnt_q        <= '0;
            freq_out_valid_q <= 1'b0;
            freq_out_data_q  <= '0;
            gate_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                gate_q           <= 1'b0;
                freq_out_valid_q <= 1'b1;
                freq_out_data_q  <= '0;
                state_q          <= S_FINISH;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !stop) begin
                            if (length == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                len_q      <= length;
                                step_idx_q <= '0;
                                state_q    <= S_READ;
                            end
                        end
                    end
                    S_READ: state_q <= S_LOAD;
                    S_LOAD: begin
                        dur_q            <= rd_data_q[DUR_W-1:0];
                        freq_out_valid_q <= 1'b1;
                        if (rd_data_q[DUR_W-1:0] == '0) begin
                            freq_out_data_q <= '0;
                            state_q         <= S_FINISH;
                        end else begin
                            freq_out_data_q <= rd_data_q[23+DUR_W:DUR_W];
                            state_q         <= S_SEND;
                        end
                    end
                    S_SEND: begin
                        if (freq_out_ready) begin
                            freq_out_valid_q <= 1'b0;
                            dur_cnt_q        <= dur_q;
                            gate_q           <= (freq_out_data_q != '0);
                            state_q          <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (tick) begin
                            if (dur_cnt_q == DUR_W'(1)) begin
                                gate_q     <= 1'b0;
                                dur_cnt_q  <= '0;
                                step_idx_q <= next_idx[AW-1:0];
                                if (next_idx != len_q) begin
                                    state_q <= S_READ;
                                end else begin
`ifdef TONE_SEQ_LOOP_EN
                                    if (loop) begin
                                        step_idx_q <= '0;
                                        state_q    <= S_READ;
                                    end else begin
                                        freq_out_valid_q <= 1'b1;
                                        freq_out_data_q  <= '0;
                                        state_q          <= S_FINISH;
                                    end
`else
                                    freq_out_valid_q <= 1'b1;
                                    freq_out_data_q  <= '0;
                                    state_q          <= S_FINISH;
`endif
                                end
                            end else begin
                                dur_cnt_q <= dur_cnt_q - 1'b1;
                            end
                        end
                    end
                    S_FINISH: begin
                        if (freq_out_ready) begin
                            freq_out_valid_q <= 1'b0;
                            done_q           <= 1'b1;
                            step_idx_q       <= '0;
                            state_q          <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign freq_out_valid = freq_out_valid_q;
    assign freq_out_data  = freq_out_data_q;
    assign gate           = gate_q;
    assign done           = done_q;
    assign step_idx       = step_idx_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer with a sample tick of 10 clocks.
// Expected beats and gate lengths come from a table-walk model of the sequencing rules.
`timescale 1ns/1ps
module tb_tone_sequencer;

    localparam int DEPTH = 16;
    localparam int DUR_W = 16;
    localparam int AW    = 4;
    localparam int TICK  = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [23:0]       wr_freq = '0;
    logic [DUR_W-1:0]  wr_dur = '0;
    logic [AW:0]       length = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop = 1'b0;
    logic              freq_out_valid;
    logic              freq_out_ready = 1'b1;
    logic [23:0]       freq_out_data;
    logic              gate;
    logic              busy;
    logic [AW-1:0]     step_idx;
    logic              done;

    tone_sequencer #(
        .DEPTH(DEPTH), .DUR_W(DUR_W), .F_SAMPLE(48_000), .F_CLOCK(480_000)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_freq(wr_freq), .wr_dur(wr_dur), .length(length), .start(start),
        .stop(stop), .loop(loop), .freq_out_valid(freq_out_valid),
        .freq_out_ready(freq_out_ready), .freq_out_data(freq_out_data),
        .gate(gate), .busy(busy), .step_idx(step_idx), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ready mode: 0 = always high, 1 = random, 2 = held low
    int ready_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                1:       freq_out_ready = ($urandom_range(0, 3) != 0);
                2:       freq_out_ready = 1'b0;
                default: freq_out_ready = 1'b1;
            endcase
        end
    end

    // Observed activity, only ever appended to by this monitor.
    logic [23:0] beats[$];
    int          gate_runs[$];
    int          run_len = 0;
    int          done_cnt = 0;
    int          busy_cycles = 0;
    int          unstable = 0;
    logic        prev_stall = 1'b0;
    logic [23:0] prev_data = '0;

    always @(negedge clk) begin
        if (reset) begin
            run_len    = 0;
            prev_stall = 1'b0;
        end else begin
            if (freq_out_valid && freq_out_ready) beats.push_back(freq_out_data);
            if (prev_stall && freq_out_valid && (freq_out_data !== prev_data)) unstable++;
            prev_stall = freq_out_valid && !freq_out_ready;
            prev_data  = freq_out_data;
            if (gate) run_len++;
            else if (run_len > 0) begin
                gate_runs.push_back(run_len);
                run_len = 0;
            end
            if (done) done_cnt++;
            if (busy) busy_cycles++;
        end
    end

    int beat_base, run_base, done_base, busy_base, unstable_base;

    task automatic mark();
        beat_base     = beats.size();
        run_base      = gate_runs.size();
        done_base     = done_cnt;
        busy_base     = busy_cycles;
        unstable_base = unstable;
    endtask

    // Model copy of the table contents.
    logic [23:0]      tbl_freq [DEPTH];
    logic [DUR_W-1:0] tbl_dur  [DEPTH];

    task automatic write_entry(input int addr, input logic [23:0] f, input logic [DUR_W-1:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = AW'(addr); wr_freq = f; wr_dur = d;
        tbl_freq[addr] = f;
        tbl_dur[addr]  = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input int len);
        @(posedge clk); #1;
        length = (AW+1)'(len);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_gate(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gate) begin ok = 1'b1; break; end
        end
    endtask

    // Scoreboard: walk the model table and compare the whole observed sequence.
    task automatic score_sequence(input string name, input int len, input bit ok);
        logic [23:0] eb[$];
        int          ed[$];
        int          nb, nr, lo, hi;
        for (int i = 0; i < len; i++) begin
            if (tbl_dur[i] == 0) break;
            eb.push_back(tbl_freq[i]);
            if (tbl_freq[i] != 0) ed.push_back(int'(tbl_dur[i]));
        end
        if (len != 0) eb.push_back(24'h0);

        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL %s.timeout: done not seen, required within budget", name); end

        nb = beats.size() - beat_base;
        n_cmp++;
        if (nb != eb.size()) begin
            n_err++; $display("FAIL %s.beat_count: got %0d, expected %0d", name, nb, eb.size());
        end else begin
            for (int i = 0; i < nb; i++) begin
                n_cmp++;
                if (beats[beat_base+i] !== eb[i]) begin
                    n_err++; $display("FAIL %s.beat[%0d]: got 0x%06h, expected 0x%06h", name, i, beats[beat_base+i], eb[i]);
                end
            end
        end

        nr = gate_runs.size() - run_base;
        n_cmp++;
        if (nr != ed.size()) begin
            n_err++; $display("FAIL %s.gate_runs: got %0d, expected %0d", name, nr, ed.size());
        end else begin
            for (int i = 0; i < nr; i++) begin
                lo = (ed[i] - 1) * TICK + 1;
                hi = ed[i] * TICK;
                n_cmp++;
                if (gate_runs[run_base+i] < lo || gate_runs[run_base+i] > hi) begin
                    n_err++; $display("FAIL %s.gate_len[%0d]: got %0d cycles, expected %0d..%0d", name, i, gate_runs[run_base+i], lo, hi);
                end
            end
        end

        n_cmp++;
        if (done_cnt - done_base != 1) begin
            n_err++; $display("FAIL %s.done_count: got %0d, expected 1", name, done_cnt - done_base);
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL %s.busy_after: got %b, expected 0", name, busy); end
        n_cmp++;
        if (unstable != unstable_base) begin
            n_err++; $display("FAIL %s.data_stable: %0d changes under backpressure, expected 0", name, unstable - unstable_base);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (freq_out_valid !== 1'b0) begin n_err++; $display("FAIL reset.valid: got %b, expected 0", freq_out_valid); end
        n_cmp++; if (freq_out_data !== 24'h0) begin n_err++; $display("FAIL reset.data: got 0x%06h, expected 0", freq_out_data); end
        n_cmp++; if (gate !== 1'b0) begin n_err++; $display("FAIL reset.gate: got %b, expected 0", gate); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset.busy: got %b, expected 0", busy); end
        n_cmp++; if (step_idx !== '0) begin n_err++; $display("FAIL reset.step_idx: got %0d, expected 0", step_idx); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset.done: got %b, expected 0", done); end
    endtask

    task automatic load_basic();
        write_entry(0, 24'(440 << 9), 16'd3);
        write_entry(1, 24'(880 << 9), 16'd2);
    endtask

    task automatic test_basic();
        bit ok;
        load_basic();
        mark();
        pulse_start(2);
        wait_done(2000, ok);
        score_sequence("basic", 2, ok);
    endtask

    task automatic test_rest_marker();
        bit ok;
        write_entry(0, 24'h0, 16'd2);
        write_entry(1, 24'(1000 << 9), 16'd0);
        mark();
        pulse_start(4);
        wait_done(2000, ok);
        score_sequence("rest_marker", 4, ok);
    endtask

    task automatic test_backpressure();
        bit ok;
        write_entry(0, 24'hA5A5A5, 16'd1);
        ready_mode = 2;
        mark();
        pulse_start(1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (freq_out_valid) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL backpressure.valid_rise: valid not seen, required"); end
        for (int i = 0; i < 7; i++) begin
            if (i != 0) @(negedge clk);
            n_cmp++;
            if (freq_out_valid !== 1'b1 || freq_out_data !== 24'hA5A5A5 || gate !== 1'b0) begin
                n_err++; $display("FAIL backpressure.hold[%0d]: valid=%b data=0x%06h gate=%b, expected 1/0xa5a5a5/0", i, freq_out_valid, freq_out_data, gate);
            end
        end
        @(posedge clk); #1 ready_mode = 0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (gate !== 1'b1 || freq_out_valid !== 1'b0) begin
            n_err++; $display("FAIL backpressure.play_start: gate=%b valid=%b, expected 1/0", gate, freq_out_valid);
        end
        wait_done(500, ok);
        score_sequence("backpressure", 1, ok);
    endtask

    task automatic test_abort();
        bit ok;
        write_entry(0, 24'(1000 << 9), 16'd5);
        write_entry(1, 24'(500 << 9), 16'd5);
        mark();
        pulse_start(2);
        wait_gate(100, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL abort.gate_rise: gate not seen, required"); end
        repeat (4) @(negedge clk);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (gate !== 1'b0 || freq_out_valid !== 1'b1 || freq_out_data !== 24'h0) begin
            n_err++; $display("FAIL abort.next_cycle: gate=%b valid=%b data=0x%06h, expected 0/1/0", gate, freq_out_valid, freq_out_data);
        end
        wait_done(100, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL abort.done: done not seen, required"); end
        n_cmp++;
        if (beats.size() - beat_base != 2 || beats[beats.size()-1] !== 24'h0 || beats[beat_base] !== 24'(1000 << 9)) begin
            n_err++; $display("FAIL abort.beats: got %0d beats, expected 2 (entry0 then 0)", beats.size() - beat_base);
        end
        n_cmp++; if (done_cnt - done_base != 1) begin n_err++; $display("FAIL abort.done_count: got %0d, expected 1", done_cnt - done_base); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort.busy: got %b, expected 0", busy); end

        mark();
        @(posedge clk); #1 length = 5'd2; start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (beats.size() != beat_base || done_cnt != done_base || busy_cycles != busy_base) begin
            n_err++; $display("FAIL abort.start_stop_idle: beats=%0d done=%0d busy_cycles=%0d, expected 0/0/0", beats.size() - beat_base, done_cnt - done_base, busy_cycles - busy_base);
        end
    endtask

    task automatic test_length_zero();
        mark();
        pulse_start(0);
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL len0.done: got %b, expected 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL len0.busy: got %b, expected 0", busy); end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (beats.size() != beat_base || done_cnt - done_base != 1) begin
            n_err++; $display("FAIL len0.activity: beats=%0d done=%0d, expected 0/1", beats.size() - beat_base, done_cnt - done_base);
        end
    endtask

    task automatic test_reset_mid_play();
        bit ok;
        load_basic();
        pulse_start(2);
        wait_gate(100, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL reset_mid.gate_rise: gate not seen, required"); end
        repeat (3) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (freq_out_valid !== 1'b0 || gate !== 1'b0 || busy !== 1'b0 || step_idx !== '0) begin
            n_err++; $display("FAIL reset_mid.outputs: valid=%b gate=%b busy=%b step=%0d, expected 0/0/0/0", freq_out_valid, gate, busy, step_idx);
        end
        @(posedge clk); #1 reset = 1'b0;
        mark();
        repeat (10) @(negedge clk);
        n_cmp++;
        if (beats.size() != beat_base || done_cnt != done_base) begin
            n_err++; $display("FAIL reset_mid.no_zero_beat: beats=%0d done=%0d, expected 0/0", beats.size() - beat_base, done_cnt - done_base);
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        load_basic();
        mark();
        pulse_start(2);
        repeat (40) @(negedge clk);
        pulse_start(1);
        wait_done(2000, ok);
        score_sequence("start_busy", 2, ok);
    endtask

    task automatic test_random();
        bit ok;
        int len;
        ready_mode = 1;
        for (int it = 0; it < 10; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                write_entry(a,
                    ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom),
                    ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 3)));
            end
            len = $urandom_range(0, DEPTH);
            mark();
            pulse_start(len);
            wait_done(6000, ok);
            score_sequence($sformatf("random%0d", it), len, ok);
        end
        ready_mode = 0;
    endtask

    task automatic test_loop();
        bit ok;
`ifdef TONE_SEQ_LOOP_EN
        write_entry(0, 24'h012345, 16'd2);
        write_entry(1, 24'h00ABCD, 16'd2);
        loop = 1'b1;
        mark();
        pulse_start(2);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (beats.size() - beat_base >= 4) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL loop.four_beats: not reached, required"); end
        n_cmp++;
        if (beats[beat_base] !== 24'h012345 || beats[beat_base+1] !== 24'h00ABCD ||
            beats[beat_base+2] !== 24'h012345 || beats[beat_base+3] !== 24'h00ABCD) begin
            n_err++; $display("FAIL loop.pattern: got %06h %06h %06h %06h, expected A B A B", beats[beat_base], beats[beat_base+1], beats[beat_base+2], beats[beat_base+3]);
        end
        n_cmp++; if (done_cnt != done_base) begin n_err++; $display("FAIL loop.no_done: got %0d, expected 0", done_cnt - done_base); end
        @(posedge clk); #1 loop = 1'b0;
        wait_done(500, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL loop.done: done not seen, required"); end
        n_cmp++;
        if (beats.size() - beat_base != 5 || beats[beat_base+4] !== 24'h0) begin
            n_err++; $display("FAIL loop.finish: got %0d beats, expected 5 ending in 0", beats.size() - beat_base);
        end
        n_cmp++; if (done_cnt - done_base != 1) begin n_err++; $display("FAIL loop.done_count: got %0d, expected 1", done_cnt - done_base); end
`else
        load_basic();
        loop = 1'b1;
        mark();
        pulse_start(2);
        wait_done(2000, ok);
        score_sequence("loop_ignored", 2, ok);
        loop = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rest_marker();
        test_backpressure();
        test_abort();
        test_length_zero();
        test_reset_mid_play();
        test_start_while_busy();
        test_random();
        test_loop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
